// File: rtl/upscale_simd_bilinear.sv
// Bilinear upscaler: maps a SRC_H x SRC_W 8-bit frame onto DST_H x DST_W,
// producing N destination pixels per COMPUTE cycle under a start/done handshake.
module upscale_simd_bilinear #(
    parameter int unsigned SRC_H = 16,
    parameter int unsigned SRC_W = 16,
    parameter int unsigned DST_H = 32,
    parameter int unsigned DST_W = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned FRAC  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] image_in  [SRC_H][SRC_W],
    output logic       busy,
    output logic       done,
    output logic [7:0] image_out [DST_H][DST_W]
);

    localparam int unsigned XR  = (((SRC_W - 1) << FRAC) + (DST_W - 1) / 2) / (DST_W - 1);
    localparam int unsigned YR  = (((SRC_H - 1) << FRAC) + (DST_H - 1) / 2) / (DST_H - 1);
    localparam int unsigned IW  = $clog2(DST_H);
    localparam int unsigned JW  = $clog2(DST_W);
    localparam int unsigned SXW = $clog2(SRC_W);
    localparam int unsigned SYW = $clog2(SRC_H);
    localparam int unsigned WW  = FRAC + 1;
    localparam int unsigned AW  = 8 + 2 * WW + 2;
    localparam int unsigned ONE = 1 << FRAC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW_SETUP,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     i_q;
    logic [JW-1:0]     j_q;
    logic [SYW-1:0]    y_l_q, y_h_q, y_l_d, y_h_d;
    logic [FRAC-1:0]   y_w_q, y_w_d;
    logic [31:0]       ys;

    logic [31:0]       xs       [N];
    logic [SXW-1:0]    x_l      [N];
    logic [SXW-1:0]    x_h      [N];
    logic [FRAC-1:0]   x_w      [N];
    logic [7:0]        lane_pix [N];

    // Exact four-tap blend with round-to-nearest and saturation.
    function automatic logic [7:0] blend(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [FRAC-1:0] xw, input logic [FRAC-1:0] yw);
        logic [WW-1:0] wx0, wy0, wx1, wy1;
        logic [AW-1:0] acc, res;
        wx1 = WW'(xw);
        wy1 = WW'(yw);
        wx0 = WW'(ONE) - wx1;
        wy0 = WW'(ONE) - wy1;
        acc = AW'(a) * AW'(wx0) * AW'(wy0) + AW'(b) * AW'(wx1) * AW'(wy0)
            + AW'(c) * AW'(wx0) * AW'(wy1) + AW'(d) * AW'(wx1) * AW'(wy1);
        res = (acc + (AW'(1) << (2 * FRAC - 1))) >> (2 * FRAC);
        return (res > AW'(255)) ? 8'hFF : res[7:0];
    endfunction

    // Row coordinate; the bottom row clamps to the last source row with zero weight.
    always_comb begin
        ys    = 32'(i_q) * YR;
        y_l_d = SYW'(SRC_H - 1);
        y_h_d = SYW'(SRC_H - 1);
        y_w_d = '0;
        if ((ys >> FRAC) < 32'(SRC_H - 1)) begin
            y_l_d = SYW'(ys >> FRAC);
            y_h_d = SYW'(ys >> FRAC) + SYW'(1);
            y_w_d = ys[FRAC-1:0];
        end
    end

    // Per-lane column coordinate and blend for columns j..j+N-1.
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            xs[k]  = (32'(j_q) + 32'(k)) * XR;
            x_l[k] = SXW'(SRC_W - 1);
            x_h[k] = SXW'(SRC_W - 1);
            x_w[k] = '0;
            if ((xs[k] >> FRAC) < 32'(SRC_W - 1)) begin
                x_l[k] = SXW'(xs[k] >> FRAC);
                x_h[k] = SXW'(xs[k] >> FRAC) + SXW'(1);
                x_w[k] = xs[k][FRAC-1:0];
            end
            lane_pix[k] = blend(image_in[y_l_q][x_l[k]], image_in[y_l_q][x_h[k]],
                                image_in[y_h_q][x_l[k]], image_in[y_h_q][x_h[k]],
                                x_w[k], y_w_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            y_l_q   <= '0;
            y_h_q   <= '0;
            y_w_q   <= '0;
            for (int r = 0; r < int'(DST_H); r++) begin
                for (int c = 0; c < int'(DST_W); c++) begin
                    image_out[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_ROW_SETUP;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        i_q     <= '0;
                    end
                end
                S_ROW_SETUP: begin
                    y_l_q   <= y_l_d;
                    y_h_q   <= y_h_d;
                    y_w_q   <= y_w_d;
                    j_q     <= '0;
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    for (int k = 0; k < int'(N); k++) begin
                        image_out[i_q][JW'(32'(j_q) + 32'(k))] <= lane_pix[k];
                    end
                    if (32'(j_q) + N == DST_W) begin
                        if (i_q == IW'(DST_H - 1)) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            i_q     <= i_q + IW'(1);
                            state_q <= S_ROW_SETUP;
                        end
                    end else begin
                        j_q <= j_q + JW'(N);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
